// File: rtl/sh_link_pkg.sv
// ============================================================================
//  sh_link_pkg
//  Shared constants and the flit type for the super-hub link endpoint.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sh_link_pkg;

  localparam int FLIT_W          = 20;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_CREDITS = 4;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage : sh_link_pkg

`default_nettype wire

// File: rtl/sh_link_fifo.sv
// ============================================================================
//  sh_link_fifo
//  Ingress flit FIFO with a combinational head output. A push and a pop in the
//  same cycle are allowed even when full, since the pop frees the head slot
//  before the write lands.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sh_link_fifo
  import sh_link_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t head,
  output logic  full,
  output logic  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  flit_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

endmodule : sh_link_fifo

`default_nettype wire

// File: rtl/sh_link_endpoint.sv
// ============================================================================
//  sh_link_endpoint
//  Super-hub side of a cluster link: credit-returning ingress FIFO on the
//  uplink and a credit-limited, registered downlink.
//  Optional feature macro: SH_LINK_STATS_EN (saturating flit counters).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sh_link_endpoint
  import sh_link_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int CREDITS = DEFAULT_CREDITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] up_data,
  input  logic        up_valid,
  output logic        up_co,
  output logic [19:0] fwd_data,
  output logic        fwd_valid,
  input  logic        fwd_ready,
  input  logic [19:0] dn_data,
  input  logic        dn_valid,
  output logic        dn_ready,
  output logic [19:0] down_data,
  output logic        down_valid,
  input  logic        down_ci,
  output logic        ovf_err,
  output logic        credit_err,
  output logic [15:0] up_count,
  output logic [15:0] down_count
);

  localparam int          CW       = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          send;
  logic          at_max;
  logic          ci_ok;
  logic [CW-1:0] credits;

  // ---------------------------------------------------------------- uplink
  assign pop       = fwd_valid && fwd_ready;
  assign push      = up_valid && (!full || pop);
  assign fwd_valid = !empty;

  sh_link_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (up_data),
    .head  (fwd_data),
    .full  (full),
    .empty (empty)
  );

  // One credit-return pulse per freed slot, one cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) up_co <= 1'b0;
    else     up_co <= pop;
  end

  // Sticky overflow flag: flit dropped because nothing left the full FIFO.
  always_ff @(posedge clk) begin
    if (rst)                          ovf_err <= 1'b0;
    else if (up_valid && full && !pop) ovf_err <= 1'b1;
  end

  // -------------------------------------------------------------- downlink
  assign dn_ready = (credits != '0);
  assign send     = dn_valid && dn_ready;
  assign at_max   = (credits == CRED_MAX);
  // A return at full credit is only legal if a send consumes one that cycle.
  assign ci_ok    = down_ci && !(at_max && !send);

  // Credit counter: send and valid return in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else begin
      case ({send, ci_ok})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for a credit return the hub could not have owed us.
  always_ff @(posedge clk) begin
    if (rst)                          credit_err <= 1'b0;
    else if (down_ci && at_max && !send) credit_err <= 1'b1;
  end

  // Registered downlink flit; data holds between sends.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_data  <= '0;
      down_valid <= 1'b0;
    end else begin
      down_valid <= send;
      if (send) down_data <= dn_data;
    end
  end

  // ------------------------------------------------------------ statistics
`ifdef SH_LINK_STATS_EN
  logic [15:0] up_cnt;
  logic [15:0] down_cnt;

  // Saturating counts of accepted uplink flits and sent downlink flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      up_cnt   <= '0;
      down_cnt <= '0;
    end else begin
      if (push && (up_cnt != 16'hFFFF))   up_cnt   <= up_cnt + 1'b1;
      if (send && (down_cnt != 16'hFFFF)) down_cnt <= down_cnt + 1'b1;
    end
  end

  assign up_count   = up_cnt;
  assign down_count = down_cnt;
`else
  assign up_count   = '0;
  assign down_count = '0;
`endif

endmodule : sh_link_endpoint

`default_nettype wire

// File: tb/tb_sh_link_endpoint.sv
// ============================================================================
//  tb_sh_link_endpoint
//  Self-checking bench: directed scenarios plus randomized traffic compared
//  against a queue-based reference model of the link endpoint.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sh_link_endpoint;

  localparam int DEPTH   = 4;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] up_data;
  logic        up_valid;
  logic        up_co;
  logic [19:0] fwd_data;
  logic        fwd_valid;
  logic        fwd_ready;
  logic [19:0] dn_data;
  logic        dn_valid;
  logic        dn_ready;
  logic [19:0] down_data;
  logic        down_valid;
  logic        down_ci;
  logic        ovf_err;
  logic        credit_err;
  logic [15:0] up_count;
  logic [15:0] down_count;

  int vectors = 0;
  int errors  = 0;

  sh_link_endpoint #(
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_co      (up_co),
    .fwd_data   (fwd_data),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .dn_data    (dn_data),
    .dn_valid   (dn_valid),
    .dn_ready   (dn_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ci    (down_ci),
    .ovf_err    (ovf_err),
    .credit_err (credit_err),
    .up_count   (up_count),
    .down_count (down_count)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------ reference model
  logic [19:0] m_q[$];
  int          m_cred;
  bit          m_ovf, m_cerr, m_up_co, m_dv;
  logic [19:0] m_dd;
  int          m_ucnt, m_dcnt;

  function automatic logic [15:0] exp_cnt(input int c);
`ifdef SH_LINK_STATS_EN
    return 16'(c);
`else
    return 16'h0;
`endif
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit pop, send;
    if (rst) begin
      m_q.delete();
      m_cred = CREDITS; m_ovf = 0; m_cerr = 0; m_up_co = 0; m_dv = 0;
      m_dd = '0; m_ucnt = 0; m_dcnt = 0;
      return;
    end
    pop  = (m_q.size() > 0) && fwd_ready;
    send = dn_valid && (m_cred > 0);
    if (up_valid) begin
      if (m_q.size() < DEPTH || pop) begin
        m_q.push_back(up_data);
        if (m_ucnt < 65535) m_ucnt++;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    m_up_co = pop;
    m_dv    = send;
    if (send) begin
      m_dd = dn_data;
      if (m_dcnt < 65535) m_dcnt++;
      m_cred--;
    end
    if (down_ci) begin
      if (m_cred == CREDITS) m_cerr = 1;
      else                   m_cred++;
    end
  endtask

  // One clock: model and DUT both take the edge, then outputs settle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    up_valid = 0; up_data = '0; fwd_ready = 0;
    dn_valid = 0; dn_data = '0; down_ci = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1;
    up_valid = 1; up_data = 20'h12345; fwd_ready = 1; dn_valid = 1; down_ci = 1;
    tick(); tick();
    idle_inputs(); rst = 0;
    vectors++;
    if (fwd_valid !== 1'b0 || up_co !== 1'b0 || down_valid !== 1'b0 || down_data !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: fwd_valid=%b up_co=%b down_valid=%b down_data=%h, required 0 0 0 00000",
               fwd_valid, up_co, down_valid, down_data);
    end
    vectors++;
    if (ovf_err !== 1'b0 || credit_err !== 1'b0 || dn_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: ovf_err=%b credit_err=%b dn_ready=%b, required 0 0 1", ovf_err, credit_err, dn_ready);
    end
    vectors++;
    if (up_count !== 16'h0 || down_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_counts: up_count=%h down_count=%h, required 0000 0000", up_count, down_count);
    end
  endtask

  task automatic test_hold_and_drain();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      up_valid = 1; up_data = 20'(i);
      tick();
      vectors++;
      if (up_co !== 1'b0) begin
        errors++;
        $display("FAIL hold_no_up_co: up_co=%b after push %0d, required 0", up_co, i);
      end
    end
    up_valid = 0;
    vectors++;
    if (fwd_valid !== 1'b1 || fwd_data !== 20'h00001) begin
      errors++;
      $display("FAIL hold_head: fwd_valid=%b fwd_data=%h, required 1 00001", fwd_valid, fwd_data);
    end
    fwd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (fwd_valid !== 1'b1 || fwd_data !== 20'(i)) begin
        errors++;
        $display("FAIL drain_order: fwd_valid=%b fwd_data=%h, required 1 %h", fwd_valid, fwd_data, 20'(i));
      end
      tick();
      vectors++;
      if (up_co !== 1'b1) begin
        errors++;
        $display("FAIL drain_up_co: up_co=%b after pop %0d, required 1", up_co, i);
      end
    end
    fwd_ready = 0;
    tick();
    vectors++;
    if (up_co !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: up_co=%b fwd_valid=%b, required 0 0", up_co, fwd_valid);
    end
  endtask

  task automatic test_overflow();
    logic [19:0] exp[$];
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      up_valid = 1; up_data = 20'($urandom);
      exp.push_back(up_data);
      tick();
    end
    up_data = 20'hABCDE; fwd_ready = 0;
    tick();
    vectors++;
    if (ovf_err !== 1'b1 || fwd_data !== exp[0]) begin
      errors++;
      $display("FAIL ovf_drop: ovf_err=%b head=%h, required 1 %h", ovf_err, fwd_data, exp[0]);
    end
    up_data = 20'hABCDE; fwd_ready = 1;
    tick();
    void'(exp.pop_front());
    exp.push_back(20'hABCDE);
    up_valid = 0;
    vectors++;
    if (ovf_err !== 1'b1 || up_count !== exp_cnt(DEPTH + 1)) begin
      errors++;
      $display("FAIL ovf_accept: ovf_err=%b up_count=%h, required 1 %h", ovf_err, up_count, exp_cnt(DEPTH + 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (fwd_valid !== 1'b1 || fwd_data !== exp[i]) begin
        errors++;
        $display("FAIL ovf_drain: fwd_data=%h, required %h", fwd_data, exp[i]);
      end
      tick();
    end
    fwd_ready = 0;
    vectors++;
    if (fwd_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: fwd_valid=%b, required 0", fwd_valid);
    end
  endtask

  task automatic test_credit_exhaust();
    int pulses = 0;
    logic [19:0] sent[$];
    apply_reset();
    dn_valid = 1;
    for (int i = 0; i < 6; i++) begin
      dn_data = 20'($urandom);
      if (dn_ready) sent.push_back(dn_data);
      tick();
      if (down_valid) begin
        pulses++;
        vectors++;
        if (down_data !== sent[pulses-1]) begin
          errors++;
          $display("FAIL exhaust_data: down_data=%h, required %h", down_data, sent[pulses-1]);
        end
      end
    end
    dn_valid = 0;
    vectors++;
    if (pulses != CREDITS || dn_ready !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_count: pulses=%0d dn_ready=%b, required %0d 0", pulses, dn_ready, CREDITS);
    end
    down_ci = 1; tick(); down_ci = 0;
    vectors++;
    if (dn_ready !== 1'b1) begin
      errors++;
      $display("FAIL exhaust_return: dn_ready=%b, required 1", dn_ready);
    end
    dn_valid = 1; dn_data = 20'h5A5A5;
    tick();
    dn_valid = 0; dn_data = 20'h00000;
    vectors++;
    if (down_valid !== 1'b1 || down_data !== 20'h5A5A5 || dn_ready !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_resend: down_valid=%b down_data=%h dn_ready=%b, required 1 5a5a5 0",
               down_valid, down_data, dn_ready);
    end
    tick();
    vectors++;
    if (down_valid !== 1'b0 || down_data !== 20'h5A5A5) begin
      errors++;
      $display("FAIL down_hold: down_valid=%b down_data=%h, required 0 5a5a5", down_valid, down_data);
    end
  endtask

  task automatic test_credit_simul();
    int sends;
    apply_reset();
    dn_valid = 1; dn_data = 20'h11111; tick(); tick();
    dn_data = 20'h22222; down_ci = 1;
    tick();
    down_ci = 0; dn_valid = 0;
    vectors++;
    if (down_valid !== 1'b1 || down_data !== 20'h22222 || credit_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_send: down_valid=%b down_data=%h credit_err=%b, required 1 22222 0",
               down_valid, down_data, credit_err);
    end
    // Remaining credits are measured by how many sends are still possible.
    sends = 0;
    dn_valid = 1;
    for (int i = 0; i < 4; i++) begin
      dn_data = 20'($urandom);
      tick();
      if (down_valid) sends++;
    end
    dn_valid = 0;
    vectors++;
    if (sends != 2) begin
      errors++;
      $display("FAIL simul_credits: sends=%0d, required 2", sends);
    end
    for (int i = 0; i < CREDITS; i++) begin
      down_ci = 1; tick();
    end
    down_ci = 0;
    vectors++;
    if (credit_err !== 1'b0) begin
      errors++;
      $display("FAIL credit_err_early: credit_err=%b, required 0", credit_err);
    end
    down_ci = 1; tick(); down_ci = 0;
    vectors++;
    if (credit_err !== 1'b1) begin
      errors++;
      $display("FAIL credit_err_set: credit_err=%b, required 1", credit_err);
    end
    sends = 0;
    dn_valid = 1;
    for (int i = 0; i < 6; i++) begin
      dn_data = 20'($urandom);
      tick();
      if (down_valid) sends++;
    end
    dn_valid = 0;
    vectors++;
    if (sends != CREDITS || credit_err !== 1'b1) begin
      errors++;
      $display("FAIL credit_max_kept: sends=%0d credit_err=%b, required %0d 1", sends, credit_err, CREDITS);
    end
  endtask

  task automatic test_reset_midflight();
    int sends;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      up_valid = 1; up_data = 20'($urandom);
      dn_valid = 1; dn_data = 20'($urandom);
      tick();
    end
    up_valid = 0; dn_valid = 0;
    fwd_ready = 1; rst = 1;
    tick();
    rst = 0;
    vectors++;
    if (fwd_valid !== 1'b0 || up_co !== 1'b0 || dn_ready !== 1'b1 || up_count !== 16'h0) begin
      errors++;
      $display("FAIL midrst_state: fwd_valid=%b up_co=%b dn_ready=%b up_count=%h, required 0 0 1 0000",
               fwd_valid, up_co, dn_ready, up_count);
    end
    sends = 0;
    dn_valid = 1;
    for (int i = 0; i < 6; i++) begin
      dn_data = 20'($urandom);
      tick();
      vectors++;
      if (up_co !== 1'b0) begin
        errors++;
        $display("FAIL midrst_up_co: up_co=%b, required 0", up_co);
      end
      if (down_valid) sends++;
    end
    idle_inputs();
    vectors++;
    if (sends != CREDITS) begin
      errors++;
      $display("FAIL midrst_credits: sends=%0d, required %0d", sends, CREDITS);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      up_valid  = ($urandom_range(0, 99) < 55);
      up_data   = 20'($urandom);
      fwd_ready = ($urandom_range(0, 99) < 45);
      dn_valid  = ($urandom_range(0, 99) < 60);
      dn_data   = 20'($urandom);
      down_ci   = ($urandom_range(0, 99) < 40);
      tick();
      vectors++;
      if (fwd_valid !== (m_q.size() != 0) || (fwd_valid && fwd_data !== m_q[0])) begin
        errors++;
        $display("FAIL rand_fwd cyc %0d: valid=%b data=%h, required valid=%b data=%h",
                 cyc, fwd_valid, fwd_data, m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 20'h0);
      end
      if (up_co !== m_up_co || dn_ready !== (m_cred != 0)) begin
        errors++;
        $display("FAIL rand_ctl cyc %0d: up_co=%b dn_ready=%b, required %b %b",
                 cyc, up_co, dn_ready, m_up_co, m_cred != 0);
      end
      if (down_valid !== m_dv || down_data !== m_dd) begin
        errors++;
        $display("FAIL rand_down cyc %0d: valid=%b data=%h, required %b %h", cyc, down_valid, down_data, m_dv, m_dd);
      end
      if (ovf_err !== m_ovf || credit_err !== m_cerr) begin
        errors++;
        $display("FAIL rand_err cyc %0d: ovf=%b cerr=%b, required %b %b", cyc, ovf_err, credit_err, m_ovf, m_cerr);
      end
      if (up_count !== exp_cnt(m_ucnt) || down_count !== exp_cnt(m_dcnt)) begin
        errors++;
        $display("FAIL rand_cnt cyc %0d: up=%h down=%h, required %h %h",
                 cyc, up_count, down_count, exp_cnt(m_ucnt), exp_cnt(m_dcnt));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_hold_and_drain();
    test_overflow();
    test_credit_exhaust();
    test_credit_simul();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_sh_link_endpoint

`default_nettype wire
